// File: rtl/uart_wb_poller_if.sv
// rtl/uart_wb_poller_if.sv - Wishbone bus between the UART poller (master) and the UART (slave)
interface uart_wb_poller_if #(
    parameter int WB_DWIDTH = 32,
    parameter int WB_SWIDTH = 4
);
    logic [31:0]          o_wb_adr;
    logic [WB_SWIDTH-1:0] o_wb_sel;
    logic                 o_wb_we;
    logic [WB_DWIDTH-1:0] o_wb_dat;
    logic                 o_wb_cyc;
    logic                 o_wb_stb;
    logic [WB_DWIDTH-1:0] i_wb_dat;
    logic                 i_wb_ack;
    logic                 i_wb_err;

    modport master (
        output o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
        input  i_wb_dat, i_wb_ack, i_wb_err
    );

    modport slave (
        input  o_wb_adr, o_wb_sel, o_wb_we, o_wb_dat, o_wb_cyc, o_wb_stb,
        output i_wb_dat, i_wb_ack, i_wb_err
    );
endinterface

// File: rtl/uart_wb_poller.sv
// rtl/uart_wb_poller.sv - Wishbone initiator that polls a UART flag register and moves TX/RX bytes
module uart_wb_poller #(
    parameter int          WB_DWIDTH   = 32,
    parameter int          WB_SWIDTH   = 4,
    parameter logic [31:0] UART_BASE   = 32'h1600_0000,
    parameter int          TXQ_DEPTH   = 4,
    parameter int          ACK_TIMEOUT = 16
) (
    input  logic                   i_clk,
    input  logic                   i_rst,
    input  logic                   i_tx_valid,
    input  logic [7:0]             i_tx_byte,
    output logic                   o_tx_ready,
    output logic                   o_rx_valid,
    output logic [7:0]             o_rx_byte,
    input  logic                   i_rx_ready,
    output logic                   o_err,
    uart_wb_poller_if.master       wb
);
    localparam int PW = $clog2(TXQ_DEPTH);
    localparam int CW = PW + 1;
    localparam int TW = $clog2(ACK_TIMEOUT + 1);
    localparam logic [31:0] DR_ADR = UART_BASE + 32'h00;
    localparam logic [31:0] FR_ADR = UART_BASE + 32'h18;
    localparam int FR_TXFF = 5;
    localparam int FR_RXFE = 4;

    typedef enum logic [2:0] {IDLE, GAP, POLL, WRITE_DR, READ_DR} state_t;

    state_t               state;
    state_t               state_nx;
    logic [7:0]           txq [TXQ_DEPTH];
    logic [PW-1:0]        rd_ptr;
    logic [PW-1:0]        wr_ptr;
    logic [CW-1:0]        count;
    logic [TW-1:0]        tmo_cnt;
    logic                 bus_active;
    logic                 term_ok;
    logic                 term_err;
    logic                 push;
    logic                 pop;
    logic                 q_nonempty;
    logic [31:0]          adr_c;
    logic [WB_SWIDTH-1:0] sel_c;
    logic                 we_c;
    logic [WB_DWIDTH-1:0] dat_c;
    logic                 cyc_c;
    logic                 unused_dat;

    assign unused_dat = ^wb.i_wb_dat[WB_DWIDTH-1:8];

    assign bus_active = (state == POLL) || (state == WRITE_DR) || (state == READ_DR);
    // err beats a same-cycle ack; a timeout only fires when neither arrived
    assign term_err   = bus_active && (wb.i_wb_err ||
                        (!wb.i_wb_ack && (tmo_cnt == TW'(ACK_TIMEOUT - 1))));
    assign term_ok    = bus_active && wb.i_wb_ack && !wb.i_wb_err;

    assign q_nonempty = (count != '0);
    assign o_tx_ready = (count < CW'(TXQ_DEPTH));
    assign push       = i_tx_valid && o_tx_ready;
    assign pop        = (state == WRITE_DR) && term_ok;

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state <= IDLE;
        end else begin
            state <= state_nx;
        end
    end

    always_comb begin
        state_nx = state;
        adr_c    = '0;
        sel_c    = '0;
        we_c     = 1'b0;
        dat_c    = '0;
        cyc_c    = 1'b0;
        case (state)
            IDLE: begin
                if (q_nonempty || !o_rx_valid) begin
                    state_nx = POLL;
                end
            end
            GAP: begin
                state_nx = IDLE;
            end
            POLL: begin
                cyc_c = 1'b1;
                adr_c = FR_ADR;
                sel_c = '1;
                if (term_err) begin
                    state_nx = GAP;
                end else if (term_ok) begin
                    if (!wb.i_wb_dat[FR_RXFE] && !o_rx_valid) begin
                        state_nx = READ_DR;
                    end else if (!wb.i_wb_dat[FR_TXFF] && q_nonempty) begin
                        state_nx = WRITE_DR;
                    end else begin
                        state_nx = GAP;
                    end
                end
            end
            WRITE_DR: begin
                cyc_c = 1'b1;
                we_c  = 1'b1;
                adr_c = DR_ADR;
                sel_c = WB_SWIDTH'(1);
                dat_c = WB_DWIDTH'(txq[rd_ptr]);
                if (term_ok || term_err) begin
                    state_nx = GAP;
                end
            end
            READ_DR: begin
                cyc_c = 1'b1;
                adr_c = DR_ADR;
                sel_c = '1;
                if (term_ok || term_err) begin
                    state_nx = GAP;
                end
            end
            default: state_nx = IDLE;
        endcase
    end

    assign wb.o_wb_adr = adr_c;
    assign wb.o_wb_sel = sel_c;
    assign wb.o_wb_we  = we_c;
    assign wb.o_wb_dat = dat_c;
    assign wb.o_wb_cyc = cyc_c;
    assign wb.o_wb_stb = cyc_c;

    // Restarts on every transaction boundary, including POLL straight into a DR access
    always_ff @(posedge i_clk) begin
        if (i_rst || !bus_active || term_ok || term_err) begin
            tmo_cnt <= '0;
        end else begin
            tmo_cnt <= tmo_cnt + TW'(1);
        end
    end

    always_ff @(posedge i_clk) begin
        if (push) begin
            txq[wr_ptr] <= i_tx_byte;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            rd_ptr <= '0;
            wr_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end

    // READ_DR is never entered while a byte is pending, so capture cannot overwrite
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_rx_valid <= 1'b0;
            o_rx_byte  <= 8'd0;
        end else if ((state == READ_DR) && term_ok) begin
            o_rx_valid <= 1'b1;
            o_rx_byte  <= wb.i_wb_dat[7:0];
        end else if (o_rx_valid && i_rx_ready) begin
            o_rx_valid <= 1'b0;
        end
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            o_err <= 1'b0;
        end else if (term_err) begin
            o_err <= 1'b1;
        end
    end
endmodule
